hamming_weight_enum: RTL
========================

HAMMING_WEIGHT_ENUM -- requirements
Module: hamming_weight_enum

Interface
REQ-001 SHALL have ports in this order, clock and reset first:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request enumeration of weight k; sampled only in IDLE.
- k  input  5  target Hamming weight, legal range 0..16.
- abort  input  1  synchronous stream cancel.
- out_valid  output  1  x holds a valid word.
- out_ready  input  1  consumer accepts x.
- x  output  16  current word, popcount(x) == k.
- last  output  1  x is the final word of the stream.
- busy  output  1  high in GEN.
- err  output  1  one-cycle pulse when start is given with k > 16.
- chk_err  output  1  sticky self-check failure flag.

REQ-002 SHALL have no parameters; widths are fixed.

Function
REQ-003 SHALL stream every 16-bit word with popcount k exactly once, in strictly ascending numeric order, C(16,k) words in total.
REQ-004 SHALL implement FSM states IDLE and GEN only.
REQ-005 IDLE: start=1 and k<=16 -> GEN, capture k, load x = (1<<k)-1 (k=16 -> 0xFFFF, k=0 -> 0x0000).
REQ-006 IDLE: start=1 and k>16 -> err=1 for exactly one cycle, stay IDLE, out_valid stays 0.
REQ-007 SHALL raise out_valid in the cycle after start is accepted (latency 1), then hold it high throughout GEN.
REQ-008 Transfer occurs on a clock edge where out_valid & out_ready; x and last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-009 On a non-final transfer, next x SHALL be the next word of the same weight (Gosper step: c=x&-x, r=x+c, next=r|(((r^x)>>2)>>ctz(c))), available the following cycle with no bubble.
REQ-010 last SHALL be 1 exactly when x == ((1<<k)-1)<<(16-k); for k=0 and k=16 the first word is also the last.
REQ-011 On a last transfer the FSM SHALL return to IDLE; out_valid and last SHALL be 0 in the next cycle.
REQ-012 start SHALL be ignored while busy; a start in the same cycle as the final transfer SHALL be ignored.
REQ-013 abort=1 in GEN SHALL force IDLE on the next edge and drop out_valid, even mid-stall; abort has priority over a concurrent transfer.
REQ-014 All intermediate arithmetic SHALL be at least 17 bits wide so r cannot wrap; the 16-bit x SHALL never wrap to a lower value.
REQ-015 In IDLE: x=0, last=0, out_valid=0, busy=0.

Reset
REQ-016 rst_n=0 SHALL asynchronously force IDLE with out_valid=0, x=0, last=0, busy=0, err=0 and chk_err=0, including mid-stream.
REQ-017 After rst_n deasserts, the first start SHALL be accepted on the first rising edge of clk.

Configuration
REQ-018 Macro HAMMING_WEIGHT_ENUM_SELFCHECK_EN:
- Defined: combinational popcount of x SHALL be compared with the captured k whenever out_valid=1; a mismatch sets chk_err, which stays 1 until reset.
- Undefined: chk_err SHALL be tied 0 and no popcount logic is instantiated.

Verification
REQ-019 k=0, out_ready=1 -> exactly one word 0x0000 with last=1, then out_valid=0.
REQ-020 k=1, out_ready=1 -> 16 words 0x0001,0x0002,...,0x8000; last only on 0x8000.
REQ-021 k=2, out_ready toggled pseudo-randomly -> 120 words, first 0x0003, 0x0005, 0x0006, final 0xC000; x stable on every stall cycle.
REQ-022 k=16 -> single word 0xFFFF with last=1; k=17 -> err high exactly one cycle, no out_valid.
REQ-023 k=8, out_ready=1 -> 12870 words, strictly ascending, each checked against a sequential reference popcount, last on 0xFF00; chk_err stays 0.
REQ-024 k=8, rst_n=0 asynchronously after the 5th transfer -> out_valid=0 and x=0 immediately; abort at word 3 -> IDLE next cycle; a new start then begins again at 0x00FF.

Source files
------------

// File: rtl/hamming_weight_enum.sv
// Streams every 16-bit word of Hamming weight k in ascending order (Gosper's hack).
// Optional popcount self-check on x: define HAMMING_WEIGHT_ENUM_SELFCHECK_EN.
//
// state | meaning
// IDLE  | waiting for start; x=0, out_valid=0
// GEN   | x holds a valid word of weight k_q, stepping on each transfer
module hamming_weight_enum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  k,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] x,
    output logic        last,
    output logic        busy,
    output logic        err,
    output logic        chk_err
);

    typedef enum logic {IDLE, GEN} state_t;

    state_t      state, state_nxt;
    logic [15:0] x_q, x_nxt;
    logic [4:0]  k_q, k_nxt;
    logic        err_q, err_nxt;

    logic [15:0] first_w, ones_q, last_word_w, gosper_w;
    logic [16:0] c_w, r_w, spread_w;
    logic [4:0]  ctz_w;
    logic        is_last;

    always_comb begin
        first_w     = 16'((17'd1 << k) - 17'd1);
        ones_q      = 16'((17'd1 << k_q) - 17'd1);
        last_word_w = ones_q << (5'd16 - k_q);
        is_last     = (state == GEN) && (x_q == last_word_w);
    end

    // 17-bit datapath so r = x + lowest-set-bit never wraps
    always_comb begin
        c_w   = {1'b0, x_q} & (~{1'b0, x_q} + 17'd1);
        r_w   = {1'b0, x_q} + c_w;
        ctz_w = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (c_w[i]) ctz_w = 5'(i);
        end
        spread_w = ((r_w ^ {1'b0, x_q}) >> 2) >> ctz_w;
        gosper_w = 16'(r_w | spread_w);
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x_q;
        k_nxt     = k_q;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (k <= 5'd16) begin
                        state_nxt = GEN;
                        k_nxt     = k;
                        x_nxt     = first_w;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            GEN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    x_nxt     = 16'd0;
                end else if (out_ready) begin
                    if (is_last) begin
                        state_nxt = IDLE;
                        x_nxt     = 16'd0;
                    end else begin
                        x_nxt = gosper_w;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                x_nxt     = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x_q   <= 16'd0;
            k_q   <= 5'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            x_q   <= x_nxt;
            k_q   <= k_nxt;
            err_q <= err_nxt;
        end
    end

    assign out_valid = (state == GEN);
    assign busy      = (state == GEN);
    assign x         = x_q;
    assign last      = is_last;
    assign err       = err_q;

`ifdef HAMMING_WEIGHT_ENUM_SELFCHECK_EN
    logic [4:0] pop_w;
    logic       chk_err_q;

    always_comb begin
        pop_w = 5'd0;
        for (int i = 0; i < 16; i++) begin
            pop_w = pop_w + {4'd0, x_q[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else if (out_valid && (pop_w != k_q)) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule
